ps2_scancode_rx: RTL and testbench

//  PS/2 keyboard receiver feeding the MiniAlu keyboard-read path (TEC instruction).

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_fifo.sv | 59 +++++
 rtl/ps2_scancode_rx.sv | 176 +++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ============================================================================
// ps2_pkg : shared types and constants for the PS/2 scancode receiver
// Rev 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2State_t;

  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
  localparam int         PS2_ENTRY_W    = 9;
  localparam int         PS2_FRAME_BITS = 11;
  localparam int         PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic oddParityOk(input logic [7:0] dataByte, input logic parityBit);
    return (^dataByte ^ parityBit) == 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_fifo.sv
// ============================================================================
// ps2_fifo : generic synchronous first-word-fall-through FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module ps2_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iPush,
  input  logic [WIDTH-1:0] iData,
  input  logic             iPop,
  output logic [WIDTH-1:0] oData,
  output logic             oFull,
  output logic             oEmpty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic             doPush;
  logic             doPop;

  assign oFull  = (count == (AW+1)'(DEPTH));
  assign oEmpty = (count == '0);
  assign doPop  = iPop && !oEmpty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign doPush = iPush && (!oFull || doPop);
  assign oData  = mem[rdPtr];

  always_ff @(posedge Clock) begin
    if (doPush) mem[wrPtr] <= iData;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_scancode_rx.sv
// ============================================================================
// ps2_scancode_rx : PS/2 keyboard deframer with break folding and scancode FIFO
// Optional: PS2_BREAK_FILTER_EN drops break-tagged codes.   Rev 1.0
// ============================================================================
`default_nettype none

module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iPS2Clk,
  input  logic       iPS2Data,
  input  logic       iPop,
  output logic [7:0] oKey,
  output logic       oBreak,
  output logic       oValid,
  output logic       oFrameErr,
  output logic       oOverflow
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [1:0] pinRaw;
  logic [1:0] lineFilt;
  logic       clkFilt;
  logic       dataFilt;

  assign pinRaw   = {iPS2Data, iPS2Clk};
  assign clkFilt  = lineFilt[0];
  assign dataFilt = lineFilt[1];

  // Per line: two-flop synchronizer, then a window that must be unanimous to flip.
  for (genvar ch = 0; ch < 2; ch++) begin : g_lineFilter
    logic                  sync1;
    logic                  sync2;
    logic                  filt;
    logic [FILTER_LEN-2:0] taps;
    logic [FILTER_LEN-1:0] window;

    assign window       = {taps, sync2};
    assign lineFilt[ch] = filt;

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        sync1 <= 1'b1;
        sync2 <= 1'b1;
        taps  <= '1;
        filt  <= 1'b1;
      end else begin
        sync1 <= pinRaw[ch];
        sync2 <= sync1;
        taps  <= window[FILTER_LEN-2:0];
        if (&window)       filt <= 1'b1;
        else if (~|window) filt <= 1'b0;
      end
    end
  end

  ps2State_t        state;
  logic [2:0]       bitCnt;
  logic [7:0]       shiftByte;
  logic             parityErr;
  logic             breakPending;
  logic             frameErr;
  logic             overflow;
  logic             clkPrev;
  logic [TO_W-1:0]  timeoutCnt;

  logic             strobe;
  logic             acceptByte;
  logic             isBreak;
  logic             pushReq;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             popEn;
  logic             dropped;
  logic [PS2_ENTRY_W-1:0] pushEntry;
  logic [PS2_ENTRY_W-1:0] headEntry;

  assign strobe     = clkPrev && !clkFilt;
  assign acceptByte = strobe && (state == ST_STOP) && dataFilt && !parityErr;
  assign isBreak    = (shiftByte == PS2_BREAK_CODE);
  assign popEn      = iPop && !fifoEmpty;
  assign dropped    = pushReq && fifoFull && !popEn;

`ifdef PS2_BREAK_FILTER_EN
  assign pushReq   = acceptByte && !isBreak && !breakPending;
  assign pushEntry = {1'b0, shiftByte};
`else
  assign pushReq   = acceptByte && !isBreak;
  assign pushEntry = {breakPending, shiftByte};
`endif

  ps2_fifo #(
    .WIDTH (PS2_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .Clock  (Clock),
    .Reset  (Reset),
    .iPush  (pushReq),
    .iData  (pushEntry),
    .iPop   (iPop),
    .oData  (headEntry),
    .oFull  (fifoFull),
    .oEmpty (fifoEmpty)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= ST_IDLE;
      bitCnt       <= '0;
      shiftByte    <= '0;
      parityErr    <= 1'b0;
      breakPending <= 1'b0;
      frameErr     <= 1'b0;
      overflow     <= 1'b0;
      clkPrev      <= 1'b1;
      timeoutCnt   <= '0;
    end else begin
      clkPrev  <= clkFilt;
      frameErr <= 1'b0;
      if (dropped) overflow <= 1'b1;
      // Any accepted non-F0 byte consumes the pending break, pushed or not.
      if (acceptByte) breakPending <= isBreak;

      if (state == ST_IDLE || strobe) timeoutCnt <= '0;
      else                            timeoutCnt <= timeoutCnt + 1'b1;

      if (state != ST_IDLE && !strobe && timeoutCnt == TO_W'(TIMEOUT_CYC - 1)) begin
        state    <= ST_IDLE;
        frameErr <= 1'b1;
      end else if (strobe) begin
        case (state)
          ST_IDLE: begin
            if (!dataFilt) begin
              state  <= ST_DATA;
              bitCnt <= '0;
            end
          end
          ST_DATA: begin
            shiftByte <= {dataFilt, shiftByte[7:1]};
            bitCnt    <= bitCnt + 3'd1;
            if (bitCnt == 3'(PS2_DATA_BITS - 1)) state <= ST_PARITY;
          end
          ST_PARITY: begin
            parityErr <= !oddParityOk(shiftByte, dataFilt);
            state     <= ST_STOP;
          end
          ST_STOP: begin
            if (!dataFilt || parityErr) frameErr <= 1'b1;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign oValid    = !fifoEmpty;
  assign oKey      = oValid ? headEntry[7:0] : 8'h00;
`ifdef PS2_BREAK_FILTER_EN
  assign oBreak    = 1'b0;
`else
  assign oBreak    = oValid && headEntry[8];
`endif
  assign oFrameErr = frameErr;
  assign oOverflow = overflow;

endmodule

`default_nettype wire

// File: tb/tb_ps2_scancode_rx.sv
// ============================================================================
// tb_ps2_scancode_rx : directed PS/2 frames with a queue-based scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ps2_scancode_rx;

  localparam int FILTER_LEN  = 8;
  localparam int FIFO_DEPTH  = 4;
  localparam int TIMEOUT_CYC = 2000;
  localparam int HALF        = 20;

  logic       Clock    = 1'b0;
  logic       Reset    = 1'b1;
  logic       iPS2Clk  = 1'b1;
  logic       iPS2Data = 1'b1;
  logic       iPop     = 1'b0;
  logic [7:0] oKey;
  logic       oBreak;
  logic       oValid;
  logic       oFrameErr;
  logic       oOverflow;

  always #10 Clock = ~Clock;

  ps2_scancode_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .iPS2Clk   (iPS2Clk),
    .iPS2Data  (iPS2Data),
    .iPop      (iPop),
    .oKey      (oKey),
    .oBreak    (oBreak),
    .oValid    (oValid),
    .oFrameErr (oFrameErr),
    .oOverflow (oOverflow)
  );

  logic [8:0] expQ[$];
  int         nChecks   = 0;
  int         nPassed   = 0;
  int         errPulses = 0;
  bit         popEnable = 1'b0;
  logic [7:0] key1C     = 8'h1C;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPassed++;
    else $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
  endtask

  // Monitor: pops the DUT head whenever allowed and compares with the scoreboard.
  always @(negedge Clock) begin
    iPop = 1'b0;
    if (oFrameErr) errPulses++;
    if (!Reset && popEnable && oValid) begin
      if (expQ.size() == 0) begin
        nChecks++;
        $display("FAIL unexpected_entry actual=0x%0h expected=none", {oBreak, oKey});
      end else begin
        check("entry", {23'd0, oBreak, oKey}, {23'd0, expQ.pop_front()});
      end
      iPop = 1'b1;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic sendBit(input logic b);
    iPS2Data = b;
    waitCycles(HALF);
    iPS2Clk = 1'b0;
    waitCycles(HALF);
    iPS2Clk = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic badParity);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit(~^b ^ badParity);
    sendBit(1'b1);
    iPS2Data = 1'b1;
    waitCycles(HALF);
  endtask

  task automatic expectEntry(input logic brk, input logic [7:0] key);
`ifdef PS2_BREAK_FILTER_EN
    if (!brk) expQ.push_back({1'b0, key});
`else
    expQ.push_back({brk, key});
`endif
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((expQ.size() != 0 || oValid) && n < 100) begin
      waitCycles(1);
      n++;
    end
    check({name, "_queue"}, expQ.size(), 0);
    check({name, "_valid"}, {31'd0, oValid}, 0);
  endtask

  initial begin
    int e0;
    waitCycles(3);
    check("reset_outputs", {20'd0, oValid, oBreak, oFrameErr, oOverflow, oKey}, 0);
    Reset = 1'b0;
    waitCycles(20);

    // 1: single make code, latency from stop-bit falling edge to oValid
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(key1C[i]);
    sendBit(~^key1C);
    iPS2Data = 1'b1;
    waitCycles(HALF);
    iPS2Clk = 1'b0;
    waitCycles(FILTER_LEN + 2);
    check("latency_before", {31'd0, oValid}, 0);
    waitCycles(1);
    check("latency_valid", {31'd0, oValid}, 1);
    check("latency_head", {23'd0, oBreak, oKey}, {23'd0, 1'b0, 8'h1C});
    waitCycles(HALF);
    iPS2Clk = 1'b1;
    waitCycles(HALF);
    expQ.push_back({1'b0, 8'h1C});
    popEnable = 1'b1;
    drain("t1");

    // 2: break prefix folding, including an extended prefix before it
    expectEntry(1'b1, 8'h1C);
    sendFrame(8'hF0, 1'b0);
    sendFrame(8'h1C, 1'b0);
    expectEntry(1'b0, 8'hE0);
    expectEntry(1'b1, 8'h75);
    sendFrame(8'hE0, 1'b0);
    sendFrame(8'hF0, 1'b0);
    sendFrame(8'h75, 1'b0);
    drain("t2");

    // 3: parity error, then a good frame
    e0 = errPulses;
    sendFrame(8'h1C, 1'b1);
    check("parity_err_pulse", errPulses, e0 + 1);
    check("parity_err_empty", {31'd0, oValid}, 0);
    expectEntry(1'b0, 8'h32);
    sendFrame(8'h32, 1'b0);
    drain("t3");

    // 4: fill the FIFO, overflow on the fifth byte
    popEnable = 1'b0;
    expectEntry(1'b0, 8'h16);
    expectEntry(1'b0, 8'h1E);
    expectEntry(1'b0, 8'h26);
    expectEntry(1'b0, 8'h25);
    sendFrame(8'h16, 1'b0);
    sendFrame(8'h1E, 1'b0);
    sendFrame(8'h26, 1'b0);
    check("overflow_not_yet", {31'd0, oOverflow}, 0);
    sendFrame(8'h25, 1'b0);
    sendFrame(8'h2E, 1'b0);
    check("overflow_set", {31'd0, oOverflow}, 1);
    check("full_valid", {31'd0, oValid}, 1);
    popEnable = 1'b1;
    drain("t4");
    check("overflow_sticky", {31'd0, oOverflow}, 1);

    // 5: partial frame abandoned by timeout
    e0 = errPulses;
    sendBit(1'b0);
    for (int i = 0; i < 5; i++) sendBit(i[0]);
    iPS2Data = 1'b1;
    waitCycles(TIMEOUT_CYC + 100);
    check("timeout_pulse", errPulses, e0 + 1);
    check("timeout_empty", {31'd0, oValid}, 0);
    expectEntry(1'b0, 8'h45);
    sendFrame(8'h45, 1'b0);
    drain("t5");

    // 6: short clock glitch with data low must not start a frame
    e0 = errPulses;
    iPS2Data = 1'b0;
    waitCycles(30);
    iPS2Clk = 1'b0;
    waitCycles(5);
    iPS2Clk = 1'b1;
    waitCycles(30);
    iPS2Data = 1'b1;
    waitCycles(30);
    expectEntry(1'b0, 8'h3C);
    sendFrame(8'h3C, 1'b0);
    drain("t6_glitch");
    check("glitch_no_err", errPulses, e0);

    // 6b: reset in the middle of a frame
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    iPS2Clk = 1'b0;
    waitCycles(5);
    Reset = 1'b1;
    waitCycles(2);
    check("midreset_outputs", {20'd0, oValid, oBreak, oFrameErr, oOverflow, oKey}, 0);
    iPS2Clk  = 1'b1;
    iPS2Data = 1'b1;
    waitCycles(5);
    Reset = 1'b0;
    waitCycles(20);
    check("midreset_no_err", errPulses, e0);
    expectEntry(1'b0, 8'h29);
    sendFrame(8'h29, 1'b0);
    drain("t6_reset");

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
